// File: rtl/mem_arbiter.sv
// Two-cache to single-memory-port arbiter: grants one cache per transaction,
// round-robin on ties, and routes read response beats back to the owner only.
module mem_arbiter #(
    parameter int unsigned ADDR_BITS  = 28,
    parameter int unsigned DATA_BITS  = 128,
    parameter int unsigned RESP_BEATS = 4
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   ic_req_valid,
    output logic                   ic_req_ready,
    input  logic [ADDR_BITS-1:0]   ic_req_addr,
    input  logic                   ic_req_rw,
    input  logic                   ic_req_data_valid,
    output logic                   ic_req_data_ready,
    input  logic [DATA_BITS-1:0]   ic_req_data_bits,
    input  logic [DATA_BITS/8-1:0] ic_req_data_mask,
    output logic                   ic_resp_valid,
    output logic [DATA_BITS-1:0]   ic_resp_data,

    input  logic                   dc_req_valid,
    output logic                   dc_req_ready,
    input  logic [ADDR_BITS-1:0]   dc_req_addr,
    input  logic                   dc_req_rw,
    input  logic                   dc_req_data_valid,
    output logic                   dc_req_data_ready,
    input  logic [DATA_BITS-1:0]   dc_req_data_bits,
    input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
    output logic                   dc_resp_valid,
    output logic [DATA_BITS-1:0]   dc_resp_data,

    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic                   mem_req_rw,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [DATA_BITS-1:0]   mem_resp_data
);

    localparam int unsigned MASK_BITS = DATA_BITS / 8;
    localparam int unsigned CNT_BITS  = (RESP_BEATS > 1) ? $clog2(RESP_BEATS) : 1;
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(RESP_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        READ_WAIT
    } state_t;

    state_t                state, state_n;
    logic                  owner, owner_n;
    logic                  rr_last, rr_last_n;
    logic [CNT_BITS-1:0]   beat_cnt, beat_cnt_n;
    logic                  req_done, req_done_n;
    logic                  data_done, data_done_n;

    logic                  own_req_valid;
    logic                  own_rw;
    logic                  own_data_valid;
    logic [ADDR_BITS-1:0]  own_addr;
    logic [DATA_BITS-1:0]  own_data;
    logic [MASK_BITS-1:0]  own_mask;

    logic                  issuing;
    logic                  reading;
    logic                  req_hs;
    logic                  data_hs;
    logic                  req_ready_grant;
    logic                  data_ready_grant;
    logic                  resp_beat;

    // Owner's request signals, selected by the current grant
    assign own_req_valid  = owner ? dc_req_valid      : ic_req_valid;
    assign own_rw         = owner ? dc_req_rw         : ic_req_rw;
    assign own_data_valid = owner ? dc_req_data_valid : ic_req_data_valid;
    assign own_addr       = owner ? dc_req_addr       : ic_req_addr;
    assign own_data       = owner ? dc_req_data_bits  : ic_req_data_bits;
    assign own_mask       = owner ? dc_req_data_mask  : ic_req_data_mask;

    assign issuing = (state == ISSUE);
    assign reading = (state == READ_WAIT);

    // Completed handshakes are masked so memory sees each exactly once
    assign mem_req_valid      = issuing && own_req_valid && !req_done;
    assign mem_req_data_valid = issuing && own_rw && own_data_valid && !data_done;
    assign mem_req_addr       = issuing ? own_addr : '0;
    assign mem_req_rw         = issuing && own_rw;
    assign mem_req_data_bits  = issuing ? own_data : '0;
    assign mem_req_data_mask  = issuing ? own_mask : '0;

    assign req_hs  = mem_req_valid && mem_req_ready;
    assign data_hs = mem_req_data_valid && mem_req_data_ready;

    assign req_ready_grant  = issuing && !req_done && mem_req_ready;
    assign data_ready_grant = issuing && own_rw && !data_done && mem_req_data_ready;

    assign ic_req_ready      = req_ready_grant && !owner;
    assign dc_req_ready      = req_ready_grant && owner;
    assign ic_req_data_ready = data_ready_grant && !owner;
    assign dc_req_data_ready = data_ready_grant && owner;

    // Response data is broadcast; only the owner's valid is raised
    assign resp_beat     = reading && mem_resp_valid;
    assign ic_resp_valid = resp_beat && !owner;
    assign dc_resp_valid = resp_beat && owner;
    assign ic_resp_data  = mem_resp_data;
    assign dc_resp_data  = mem_resp_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            rr_last   <= 1'b1;
            beat_cnt  <= '0;
            req_done  <= 1'b0;
            data_done <= 1'b0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            rr_last   <= rr_last_n;
            beat_cnt  <= beat_cnt_n;
            req_done  <= req_done_n;
            data_done <= data_done_n;
        end
    end

    always_comb begin
        state_n     = state;
        owner_n     = owner;
        rr_last_n   = rr_last;
        beat_cnt_n  = beat_cnt;
        req_done_n  = req_done;
        data_done_n = data_done;

        case (state)
            IDLE: begin
                if (ic_req_valid && dc_req_valid) begin
                    owner_n = !rr_last;
                    state_n = ISSUE;
                end else if (ic_req_valid) begin
                    owner_n = 1'b0;
                    state_n = ISSUE;
                end else if (dc_req_valid) begin
                    owner_n = 1'b1;
                    state_n = ISSUE;
                end
            end

            ISSUE: begin
                if (!own_rw) begin
                    if (req_hs) begin
                        state_n    = READ_WAIT;
                        beat_cnt_n = '0;
                    end
                end else if ((req_done || req_hs) && (data_done || data_hs)) begin
                    state_n     = IDLE;
                    req_done_n  = 1'b0;
                    data_done_n = 1'b0;
                    rr_last_n   = owner;
                end else begin
                    req_done_n  = req_done || req_hs;
                    data_done_n = data_done || data_hs;
                end
            end

            READ_WAIT: begin
                if (mem_resp_valid) begin
                    if (beat_cnt == LAST_BEAT) begin
                        state_n    = IDLE;
                        beat_cnt_n = '0;
                        rr_last_n  = owner;
                    end else begin
                        beat_cnt_n = beat_cnt + CNT_BITS'(1);
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed cache/memory stimulus, with a
// monitor checking every memory handshake and response beat against queues.
module tb_mem_arbiter;

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 128;
    localparam int unsigned MW = DW / 8;

    logic          clk;
    logic          reset;
    logic          ic_req_valid, ic_req_ready, ic_req_rw, ic_req_data_valid, ic_req_data_ready;
    logic [AW-1:0] ic_req_addr;
    logic [DW-1:0] ic_req_data_bits, ic_resp_data;
    logic [MW-1:0] ic_req_data_mask;
    logic          ic_resp_valid;
    logic          dc_req_valid, dc_req_ready, dc_req_rw, dc_req_data_valid, dc_req_data_ready;
    logic [AW-1:0] dc_req_addr;
    logic [DW-1:0] dc_req_data_bits, dc_resp_data;
    logic [MW-1:0] dc_req_data_mask;
    logic          dc_resp_valid;
    logic          mem_req_valid, mem_req_ready, mem_req_rw;
    logic          mem_req_data_valid, mem_req_data_ready;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data_bits;
    logic [MW-1:0] mem_req_data_mask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;

    mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .RESP_BEATS(4)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_req_rw(ic_req_rw), .ic_req_data_valid(ic_req_data_valid),
        .ic_req_data_ready(ic_req_data_ready), .ic_req_data_bits(ic_req_data_bits),
        .ic_req_data_mask(ic_req_data_mask), .ic_resp_valid(ic_resp_valid),
        .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
        .dc_req_rw(dc_req_rw), .dc_req_data_valid(dc_req_data_valid),
        .dc_req_data_ready(dc_req_data_ready), .dc_req_data_bits(dc_req_data_bits),
        .dc_req_data_mask(dc_req_data_mask), .dc_resp_valid(dc_resp_valid),
        .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; logic rw; } req_t;
    typedef struct { logic [DW-1:0] data; logic [MW-1:0] mask; } wdata_t;

    req_t          exp_req[$];
    wdata_t        exp_wd[$];
    logic [DW-1:0] exp_ic[$];
    logic [DW-1:0] exp_dc[$];

    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        failed++;
        $display("FAIL %s: DUT event with no expected entry queued", name);
    endtask

    // Pops and compares whenever the DUT presents a handshake or a response beat
    task automatic monitor();
        req_t   r;
        wdata_t w;
        forever begin
            @(negedge clk);
            if (mem_req_valid && mem_req_ready) begin
                if (exp_req.size() == 0) unexpected("mem_req");
                else begin
                    r = exp_req.pop_front();
                    check("mem_req_addr", DW'(mem_req_addr), DW'(r.addr));
                    check_bit("mem_req_rw", mem_req_rw, r.rw);
                end
            end
            if (mem_req_data_valid && mem_req_data_ready) begin
                if (exp_wd.size() == 0) unexpected("mem_req_data");
                else begin
                    w = exp_wd.pop_front();
                    check("mem_req_data_bits", mem_req_data_bits, w.data);
                    check("mem_req_data_mask", DW'(mem_req_data_mask), DW'(w.mask));
                end
            end
            if (ic_resp_valid) begin
                if (exp_ic.size() == 0) unexpected("ic_resp");
                else check("ic_resp_data", ic_resp_data, exp_ic.pop_front());
            end
            if (dc_resp_valid) begin
                if (exp_dc.size() == 0) unexpected("dc_resp");
                else check("dc_resp_data", dc_resp_data, exp_dc.pop_front());
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input logic side);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (side ? dc_req_ready : ic_req_ready) return;
        end
        tests++;
        failed++;
        $display("FAIL grant_timeout: side %0d saw no req_ready within 50 cycles", side);
    endtask

    task automatic push_beats(input logic side, input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            if (side) exp_dc.push_back(base + DW'(i));
            else      exp_ic.push_back(base + DW'(i));
        end
    endtask

    task automatic send_beats(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            mem_resp_valid = 1'b1;
            mem_resp_data  = base + DW'(i);
        end
        tick();
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ic_req_valid = 1'b0; ic_req_addr = '0; ic_req_rw = 1'b0; ic_req_data_valid = 1'b0;
        ic_req_data_bits = '0; ic_req_data_mask = '0;
        dc_req_valid = 1'b0; dc_req_addr = '0; dc_req_rw = 1'b0; dc_req_data_valid = 1'b0;
        dc_req_data_bits = '0; dc_req_data_mask = '0;
        mem_req_ready = 1'b1; mem_req_data_ready = 1'b1;
        mem_resp_valid = 1'b0; mem_resp_data = '0;

        fork
            monitor();
        join_none

        // Reset state
        @(negedge clk);
        check_bit("rst_mem_req_valid", mem_req_valid, 1'b0);
        check_bit("rst_mem_req_data_valid", mem_req_data_valid, 1'b0);
        check_bit("rst_ic_req_ready", ic_req_ready, 1'b0);
        check_bit("rst_dc_req_ready", dc_req_ready, 1'b0);
        check_bit("rst_ic_resp_valid", ic_resp_valid, 1'b0);
        check_bit("rst_dc_resp_valid", dc_resp_valid, 1'b0);
        tick();
        reset = 1'b0;

        // icache read alone
        exp_req.push_back('{addr: 28'h0000040, rw: 1'b0});
        push_beats(1'b0, 128'hA0, 4);
        ic_req_valid = 1'b1; ic_req_rw = 1'b0; ic_req_addr = 28'h0000040;
        wait_grant(1'b0);
        check_bit("t1_dc_ready_low", dc_req_ready, 1'b0);
        tick();
        ic_req_valid = 1'b0;
        @(negedge clk);
        check_bit("t1_no_second_req", mem_req_valid, 1'b0);
        send_beats(128'hA0, 4);

        // Stray response beat in IDLE
        tick();
        mem_resp_valid = 1'b1; mem_resp_data = 128'h5A5A;
        @(negedge clk);
        check_bit("stray_ic_resp_valid", ic_resp_valid, 1'b0);
        check_bit("stray_dc_resp_valid", dc_resp_valid, 1'b0);
        check("stray_ic_resp_data", ic_resp_data, 128'h5A5A);
        check("stray_dc_resp_data", dc_resp_data, 128'h5A5A);
        check_bit("stray_mem_req_valid", mem_req_valid, 1'b0);
        tick();
        mem_resp_valid = 1'b0;

        // Simultaneous repeating requests from a fresh reset: ic, dc, ic, dc
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_req.push_back('{addr: 28'h0000080, rw: 1'b0});
        exp_req.push_back('{addr: 28'h0000123, rw: 1'b1});
        exp_req.push_back('{addr: 28'h00000C0, rw: 1'b0});
        exp_req.push_back('{addr: 28'h0000124, rw: 1'b1});
        exp_wd.push_back('{data: 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE, mask: 16'hFFFF});
        exp_wd.push_back('{data: 128'hBEEF_0000_1111_2222_3333_4444_5555_6666, mask: 16'h0F0F});
        push_beats(1'b0, 128'hB0, 4);
        push_beats(1'b0, 128'hC0, 4);
        ic_req_valid = 1'b1; ic_req_rw = 1'b0; ic_req_addr = 28'h0000080;
        dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = 28'h0000123;
        dc_req_data_valid = 1'b1;
        dc_req_data_bits = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        dc_req_data_mask = 16'hFFFF;
        wait_grant(1'b0);
        check_bit("t2_nonowner_ready", dc_req_ready, 1'b0);
        tick();
        ic_req_addr = 28'h00000C0;
        send_beats(128'hB0, 4);
        wait_grant(1'b1);
        check_bit("t2_dc_data_ready", dc_req_data_ready, 1'b1);
        check_bit("t2_ic_ready_low", ic_req_ready, 1'b0);
        tick();
        dc_req_addr = 28'h0000124;
        dc_req_data_bits = 128'hBEEF_0000_1111_2222_3333_4444_5555_6666;
        dc_req_data_mask = 16'h0F0F;
        wait_grant(1'b0);
        tick();
        ic_req_valid = 1'b0;
        send_beats(128'hC0, 4);
        wait_grant(1'b1);
        tick();
        dc_req_valid = 1'b0; dc_req_data_valid = 1'b0;

        // Write data accepted two cycles after the request
        exp_req.push_back('{addr: 28'h0000200, rw: 1'b1});
        exp_wd.push_back('{data: 128'h1111_2222_3333_4444, mask: 16'h00FF});
        mem_req_data_ready = 1'b0;
        dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = 28'h0000200;
        dc_req_data_valid = 1'b1; dc_req_data_bits = 128'h1111_2222_3333_4444;
        dc_req_data_mask = 16'h00FF;
        wait_grant(1'b1);
        check_bit("t3_data_ready_low", dc_req_data_ready, 1'b0);
        tick();
        @(negedge clk);
        check_bit("t3_req_valid_masked", mem_req_valid, 1'b0);
        check_bit("t3_data_valid_held", mem_req_data_valid, 1'b1);
        check_bit("t3_dc_ready_after_hs", dc_req_ready, 1'b0);
        tick();
        mem_req_data_ready = 1'b1;
        @(negedge clk);
        check_bit("t3_dc_data_ready", dc_req_data_ready, 1'b1);
        tick();
        dc_req_valid = 1'b0; dc_req_data_valid = 1'b0;
        @(negedge clk);
        check_bit("t3_idle_req_valid", mem_req_valid, 1'b0);
        check_bit("t3_idle_data_valid", mem_req_data_valid, 1'b0);

        // Write with request and data accepted in the same cycle
        exp_req.push_back('{addr: 28'h0000300, rw: 1'b1});
        exp_wd.push_back('{data: 128'h2222_AAAA, mask: 16'hF0F0});
        ic_req_valid = 1'b1; ic_req_rw = 1'b1; ic_req_addr = 28'h0000300;
        ic_req_data_valid = 1'b1; ic_req_data_bits = 128'h2222_AAAA; ic_req_data_mask = 16'hF0F0;
        wait_grant(1'b0);
        check_bit("t4_ic_data_ready", ic_req_data_ready, 1'b1);
        check_bit("t4_dc_data_ready", dc_req_data_ready, 1'b0);
        tick();
        ic_req_valid = 1'b0; ic_req_data_valid = 1'b0; ic_req_rw = 1'b0;
        @(negedge clk);
        check_bit("t4_idle_req_valid", mem_req_valid, 1'b0);
        check_bit("t4_idle_data_valid", mem_req_data_valid, 1'b0);
        check_bit("t4_idle_ic_ready", ic_req_ready, 1'b0);

        // Asynchronous reset after two of four read beats
        exp_req.push_back('{addr: 28'h0000400, rw: 1'b0});
        push_beats(1'b0, 128'hD0, 2);
        ic_req_valid = 1'b1; ic_req_addr = 28'h0000400;
        wait_grant(1'b0);
        tick();
        ic_req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            mem_resp_valid = 1'b1;
            mem_resp_data  = 128'hD0 + DW'(i);
        end
        tick();
        mem_resp_data = 128'hD2;
        #2 reset = 1'b1;
        #1;
        check_bit("t5_async_ic_resp_valid", ic_resp_valid, 1'b0);
        check_bit("t5_async_dc_resp_valid", dc_resp_valid, 1'b0);
        check_bit("t5_async_mem_req_valid", mem_req_valid, 1'b0);
        tick();
        reset = 1'b0;
        mem_resp_data = 128'hD3;
        @(negedge clk);
        check_bit("t5_dropped_ic_resp", ic_resp_valid, 1'b0);
        check_bit("t5_dropped_dc_resp", dc_resp_valid, 1'b0);
        tick();
        mem_resp_valid = 1'b0;

        // Tie after reset goes to icache; dc read then routes only to dcache
        exp_req.push_back('{addr: 28'h0000500, rw: 1'b0});
        exp_req.push_back('{addr: 28'h0000600, rw: 1'b0});
        push_beats(1'b0, 128'hE0, 4);
        push_beats(1'b1, 128'hF0, 4);
        ic_req_valid = 1'b1; ic_req_rw = 1'b0; ic_req_addr = 28'h0000500;
        dc_req_valid = 1'b1; dc_req_rw = 1'b0; dc_req_addr = 28'h0000600;
        wait_grant(1'b0);
        check_bit("t6_tie_dc_ready_low", dc_req_ready, 1'b0);
        tick();
        ic_req_valid = 1'b0;
        send_beats(128'hE0, 4);
        wait_grant(1'b1);
        tick();
        dc_req_valid = 1'b0;
        send_beats(128'hF0, 4);

        repeat (3) tick();
        check("left_exp_req", DW'(exp_req.size()), DW'(0));
        check("left_exp_wd", DW'(exp_wd.size()), DW'(0));
        check("left_exp_ic", DW'(exp_ic.size()), DW'(0));
        check("left_exp_dc", DW'(exp_dc.size()), DW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and the data cache. Merges their two miss/writeback memory interfaces onto the single main-memory port.
- Grants one cache at a time and holds the grant for the whole transaction: one read (RESP_BEATS response beats) or one write (one request plus one data beat).
- Routes memory responses back to the owning cache only.
- Round-robin fairness between the caches when both request in the same cycle.

Parameters:
- ADDR_BITS, 28, width of the memory line address (word address bits [29:2]).
- DATA_BITS, 128, `MEM_DATA_BITS, width of one memory beat.
- RESP_BEATS, 4, response beats returned per read request (one 512-bit cache line).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ic_req_valid  in  1  icache memory request valid
- ic_req_ready  out  1  icache request accepted
- ic_req_addr  in  ADDR_BITS  icache line address
- ic_req_rw  in  1  1=write, 0=read
- ic_req_data_valid  in  1  icache write data valid
- ic_req_data_ready  out  1  icache write data accepted
- ic_req_data_bits  in  DATA_BITS  icache write data
- ic_req_data_mask  in  DATA_BITS/8  icache byte mask
- ic_resp_valid  out  1  response beat for icache
- ic_resp_data  out  DATA_BITS  response data for icache
- dc_*  (same 10 signals, same directions and widths)  data-cache side
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_BITS  forwarded address
- mem_req_rw  out  1  forwarded rw
- mem_req_data_valid  out  1  forwarded write data valid
- mem_req_data_ready  in  1  memory accepts write data
- mem_req_data_bits  out  DATA_BITS  forwarded write data
- mem_req_data_mask  out  DATA_BITS/8  forwarded mask
- mem_resp_valid  in  1  memory response beat valid
- mem_resp_data  in  DATA_BITS  memory response data

Behaviour:
- State register: IDLE, ISSUE, READ_WAIT. Registers:
  - owner (0=ic, 1=dc)
  - rr_last (last granted)
  - beat_cnt (ceilLog2(RESP_BEATS) bits)
  - req_done, data_done flags
- Reset (async): state=IDLE, owner=0, rr_last=1 (icache wins the first tie), beat_cnt=0, flags=0. All outputs deasserted; valid/ready outputs 0. Reset mid-transaction abandons it; any in-flight memory beats after reset are dropped while in IDLE.
- IDLE: if exactly one *_req_valid is high, that cache becomes owner. If both are high, owner = !rr_last. Move to ISSUE the next cycle. No request is forwarded in IDLE; grant latency is 1 cycle.
- ISSUE: mem_req_* is driven combinationally from the owner's signals, and mem_req_ready/mem_req_data_ready are passed back to the owner only. The non-owner sees ready=0 and resp_valid=0.
  - Read (rw=0): on mem_req_valid&&mem_req_ready, go to READ_WAIT with beat_cnt=0.
  - Write (rw=1): the request handshake sets req_done and the data handshake sets data_done; they may occur in the same or different cycles and in either order. Once a handshake completes, its valid is masked to memory. When both are done (including same-cycle completion), return to IDLE, clear the flags and set rr_last=owner.
  - Owner dropping req_valid before acceptance: hold ISSUE with mem_req_valid low. No timeout.
- READ_WAIT: each mem_resp_valid asserts owner_resp_valid in the same cycle (combinational pass-through, zero latency) with resp_data=mem_resp_data, and increments beat_cnt. The beat with beat_cnt==RESP_BEATS-1 returns to IDLE and sets rr_last=owner.
  - New requests are not accepted during READ_WAIT (one outstanding transaction).
- *_resp_data is driven with mem_resp_data to both caches at all times; only resp_valid is gated.
- mem_resp_valid outside READ_WAIT is a protocol error: dropped, no state change.
- beat_cnt wraps to 0 on the final beat.

Test Plan:
- icache read alone: ic_req_valid=1, rw=0, addr=28'h0000040, mem ready at the first ISSUE cycle, 4 resp beats A0..A3 -> mem_req_addr=0x40 for one handshake; ic_resp_valid pulses 4x with A0..A3; dc_resp_valid stays 0; IDLE after the 4th beat.
- Simultaneous requests, both repeating (ic read, dc write addr 0x123, data 128'hDEAD..., mask FFFF) -> icache served first. The dcache write is forwarded with mask 16'hFFFF and returns to IDLE after both handshakes. The third grant goes to icache again (alternation).
- Write with data accepted 2 cycles after the request (mem_req_data_ready late) -> mem_req_valid drops after its handshake, data_valid held; IDLE only after the data handshake.
- Write with request and data accepted in the same cycle -> IDLE the next cycle; exactly one of each handshake seen at memory.
- Reset asserted asynchronously after 2 of 4 read beats -> outputs 0 immediately; the remaining 2 mem_resp_valid beats produce no ic/dc resp_valid; next tie grants icache.
- Stray mem_resp_valid in IDLE -> no resp_valid to either cache, state unchanged.
